echo_delay_line: RTL and testbench
==================================

// Module: echo_delay_line
// PURPOSE
//  Produces the echo term consumed by the note combiner: stores each mixed output
//  sample in a circular RAM and, DELAY_LEN samples later, returns it attenuated by
//  a right shift. Sits in the audio path between the combiner output and the
//  combiner's delay input; advances only on the codec sample strobe.
// PARAMETERS
//  DATA_W      18    width of mixed sample in and echo sample out (unsigned)
//  ADDR_W      12    RAM address width; DEPTH = 2**ADDR_W samples
//  ATTEN_SHIFT 2     echo attenuation: echo = stored_sample >> ATTEN_SHIFT
// PORTS
//  clk          in   1       system clock
//  reset_n      in   1       asynchronous, active-low reset
//  enable       in   1       echo on; low forces IDLE and zero output
//  delay_len    in   ADDR_W  echo delay in samples; 0 = echo disabled
//  sample_valid in   1       one-cycle strobe: sample_in holds a new mixed sample
//  sample_in    in   DATA_W  mixed sample from combiner
//  echo_out     out  DATA_W  attenuated delayed sample (held between updates)
//  echo_valid   out  1       one-cycle pulse when echo_out updates
//  overrun      out  1       sticky: strobe arrived while FSM busy; cleared by reset/!enable
// BEHAVIOUR
//  Reset (async, reset_n=0): FSM=IDLE, wr_ptr=0, fill_cnt=0, echo_out=0,
//   echo_valid=0, overrun=0. RAM contents not cleared (fill_cnt masks them).
//  FSM: IDLE -> WAIT when enable=1. WAIT -> READ on sample_valid (latch sample_in).
//   READ: RAM addr = rd_ptr = (wr_ptr - delay_len) mod DEPTH, sync read issued.
//   WRITE: RAM rdata valid; write latched sample at wr_ptr; echo_out updated;
//   echo_valid=1; wr_ptr++ (wraps DEPTH-1 -> 0). WRITE -> WAIT.
//  Latency: sample_valid at cycle N -> echo_valid/echo_out at N+2. Strobes must be
//   >= 3 cycles apart; a strobe in READ or WRITE is dropped and sets overrun.
//  Read-before-write: read of slot precedes its overwrite, so delay_len samples of
//   history are exact; max delay_len = DEPTH-1.
//  Fill: fill_cnt saturates at delay_len; while fill_cnt < delay_len, echo_out=0
//   (echo_valid still pulses). fill_cnt increments in WRITE.
//  Arithmetic: echo_out = rdata >> ATTEN_SHIFT, logical, zero-fill, no rounding.
//  delay_len=0: echo_out=0 on every WRITE; RAM still written.
//  delay_len change (sampled each cycle vs registered copy): fill_cnt <- 0 next
//   cycle; an in-flight READ/WRITE completes with echo_out=0.
//  enable falls: any state -> IDLE next cycle, echo_out=0, fill_cnt=0, overrun=0,
//   wr_ptr held; pending sample discarded, no echo_valid.
//  Reset mid-operation: all registers to reset values immediately; no RAM write.
// STRUCTURE
//  Shared header echo_defs.vh: FSM state encodings (IDLE, WAIT, READ, WRITE),
//   default DATA_W/ADDR_W/ATTEN_SHIFT constants shared with combiner and top level.
//  One sub-module: delay_ram - single-port synchronous RAM, registered read,
//   write-enable, DATA_W x 2**ADDR_W. Top module holds FSM, pointers, fill, output.
// TESTING
//  1 Reset: reset_n=0 mid-WRITE -> echo_out=0, echo_valid=0, overrun=0 at once.
//  2 delay_len=3, samples 100,200,300,400,500 -> echo_out 0,0,0,25,50, each
//    pulse exactly 2 cycles after its strobe.
//  3 Wrap: ADDR_W=4, delay_len=15, 40 ramp samples k=4*i -> from sample 15 on,
//    echo_out = (k-60)>>2 = i-15; no glitch at wr_ptr 15->0.
//  4 Full-scale: sample 18'h3FFFF, delay_len=1 -> next echo_out = 18'h0FFFF.
//  5 Overrun: strobes 1 cycle apart -> second dropped, overrun=1 and stays 1
//    until enable=0; one echo_valid only.
//  6 delay_len 2->5 mid-stream -> next 5 echo_out values 0, then samples from
//    5 strobes earlier >>2; delay_len=0 -> all echo_out 0.

Source files
------------

// File: rtl/echo_delay_line_pkg.sv
// Package: echo_delay_line_pkg
// Shared definitions for the echo delay line: default widths used by the
// combiner and the top level, and the FSM state encoding.
package echo_delay_line_pkg;

    localparam int unsigned DefDataW      = 18;
    localparam int unsigned DefAddrW      = 12;
    localparam int unsigned DefAttenShift = 2;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWait  = 2'd1,
        StRead  = 2'd2,
        StWrite = 2'd3
    } state_e;

endpackage

// File: rtl/echo_delay_line_ram.sv
// Module: echo_delay_line_ram
// Single-port synchronous RAM, DATA_W x 2**ADDR_W, registered read.
// Contents are not reset; the caller masks stale data.
// Ports:
//   clk    in   system clock
//   we     in   write enable (writes wdata at addr)
//   re     in   read enable (rdata <= mem[addr] on the next edge)
//   addr   in   shared read/write address
//   wdata  in   write data
//   rdata  out  registered read data
module echo_delay_line_ram #(
    parameter int unsigned DATA_W = 18,
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/echo_delay_line.sv
// Module: echo_delay_line
// Stores every mixed sample in a circular RAM and returns the sample written
// delay_len strobes earlier, attenuated by a logical right shift.
// Ports:
//   clk           in   system clock
//   reset_n       in   asynchronous active-low reset
//   enable        in   echo on; low forces idle and zero output
//   delay_len     in   echo delay in samples (0 disables the echo)
//   sample_valid  in   one-cycle strobe, sample_in holds a new sample
//   sample_in     in   mixed sample from the combiner
//   echo_out      out  attenuated delayed sample, held between updates
//   echo_valid    out  one-cycle pulse when echo_out updates
//   overrun       out  sticky: a strobe arrived while a transfer was in flight
module echo_delay_line
    import echo_delay_line_pkg::*;
#(
    parameter int unsigned DATA_W      = DefDataW,
    parameter int unsigned ADDR_W      = DefAddrW,
    parameter int unsigned ATTEN_SHIFT = DefAttenShift
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [ADDR_W-1:0] delay_len,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_in,
    output logic [DATA_W-1:0] echo_out,
    output logic              echo_valid,
    output logic              overrun
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] fill_cnt_q, fill_cnt_d;
    logic [ADDR_W-1:0] delay_q, delay_d;
    logic [DATA_W-1:0] sample_q, sample_d;
    logic [DATA_W-1:0] echo_q, echo_d;
    logic              overrun_q, overrun_d;

    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_rdata;
    logic              ram_we;
    logic              ram_re;
    logic              delay_chg;
    logic              write_fire;
    logic [DATA_W-1:0] echo_calc;

    // Modular subtraction wraps naturally at ADDR_W bits.
    assign rd_ptr     = wr_ptr_q - delay_len;
    assign delay_chg  = (delay_len != delay_q);
    assign write_fire = (state_q == StWrite) && enable;
    assign ram_we     = write_fire;
    assign ram_re     = (state_q == StRead) && enable;
    // Read slot is fetched in READ, the same slot is only overwritten later.
    assign ram_addr   = (state_q == StWrite) ? wr_ptr_q : rd_ptr;

    // Unfilled history, a disabled echo, or a delay change in flight all yield zero.
    always_comb begin
        echo_calc = '0;
        if (!delay_chg && (delay_q != '0) && (fill_cnt_q >= delay_q)) begin
            echo_calc = ram_rdata >> ATTEN_SHIFT;
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        fill_cnt_d = fill_cnt_q;
        delay_d    = delay_len;
        sample_d   = sample_q;
        echo_d     = echo_q;
        overrun_d  = overrun_q;
        if (!enable) begin
            state_d    = StIdle;
            echo_d     = '0;
            fill_cnt_d = '0;
            overrun_d  = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: state_d = StWait;
                StWait: begin
                    if (sample_valid) begin
                        state_d  = StRead;
                        sample_d = sample_in;
                    end
                end
                StRead: state_d = StWrite;
                StWrite: begin
                    state_d  = StWait;
                    echo_d   = echo_calc;
                    wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                    if (fill_cnt_q < delay_q) begin
                        fill_cnt_d = fill_cnt_q + ADDR_W'(1);
                    end
                end
            endcase
            if (sample_valid && ((state_q == StRead) || (state_q == StWrite))) begin
                overrun_d = 1'b1;
            end
            if (delay_chg) begin
                fill_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            fill_cnt_q <= '0;
            delay_q    <= '0;
            sample_q   <= '0;
            echo_q     <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            fill_cnt_q <= fill_cnt_d;
            delay_q    <= delay_d;
            sample_q   <= sample_d;
            echo_q     <= echo_d;
            overrun_q  <= overrun_d;
        end
    end

    echo_delay_line_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (sample_q),
        .rdata (ram_rdata)
    );

    // The fresh echo is shown in the WRITE cycle itself so it lands two cycles
    // after the strobe; echo_q holds it afterwards.
    assign echo_out   = write_fire ? echo_calc : echo_q;
    assign echo_valid = write_fire;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_echo_delay_line.sv
module tb_echo_delay_line;

    localparam int DW = 18;
    localparam int AW = 4;
    localparam int SH = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic [AW-1:0] delay_len = '0;
    logic          sample_valid = 1'b0;
    logic [DW-1:0] sample_in = '0;
    logic [DW-1:0] echo_out;
    logic          echo_valid;
    logic          overrun;

    echo_delay_line #(
        .DATA_W      (DW),
        .ADDR_W      (AW),
        .ATTEN_SHIFT (SH)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .delay_len    (delay_len),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .echo_out     (echo_out),
        .echo_valid   (echo_valid),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [DW-1:0] val;
        int            cyc;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] hist[$];
    int            since = 0;
    int            cur_dly = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every echo pulse consumes one expected entry.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (reset_n && echo_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_echo_valid: got pulse echo_out=%0h, required none", echo_out);
                end else begin
                    e = sb.pop_front();
                    check("echo_out", echo_out, e.val);
                    check_int("echo_latency", cyc, e.cyc);
                end
            end
        end
    end

    // Reference: echo is the sample written delay writes ago, once that many
    // writes have occurred since the last delay change / disable / reset.
    task automatic strobe(input logic [DW-1:0] s);
        exp_t          e;
        logic [DW-1:0] v;
        hist.push_back(s);
        if (cur_dly != 0 && since >= cur_dly) v = hist[hist.size() - 1 - cur_dly] >> SH;
        else v = '0;
        since++;
        e.val = v;
        e.cyc = cyc + 2;
        sb.push_back(e);
        sample_in = s;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        sample_in = DW'($urandom);
    endtask

    task automatic send_gap(input logic [DW-1:0] s);
        strobe(s);
        repeat (2) @(negedge clk);
    endtask

    // Strobe one cycle after the previous one: must be dropped.
    task automatic dup_strobe();
        sample_in = DW'($urandom);
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic set_delay(input int d);
        @(negedge clk);
        if (d != cur_dly) since = 0;
        cur_dly = d;
        delay_len = AW'(d);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [DW-1:0] ramp [5];
        ramp = '{18'd100, 18'd200, 18'd300, 18'd400, 18'd500};

        repeat (2) @(negedge clk);
        check("reset_echo_out", echo_out, '0);
        check("reset_echo_valid", DW'(echo_valid), '0);
        check("reset_overrun", DW'(overrun), '0);
        reset_n = 1'b1;
        set_delay(3);
        enable = 1'b1;
        repeat (2) @(negedge clk);

        // Basic delay 3
        for (int i = 0; i < 5; i++) send_gap(ramp[i]);

        // Full-scale, delay 1
        set_delay(1);
        send_gap(18'h3FFFF);
        send_gap(18'h00005);

        // Pointer wrap with maximum delay
        set_delay(15);
        for (int i = 0; i < 40; i++) send_gap(DW'(4 * i));

        // Delay changes mid-stream
        set_delay(2);
        for (int i = 0; i < 6; i++) send_gap(DW'($urandom));
        set_delay(5);
        for (int i = 0; i < 10; i++) send_gap(DW'($urandom));
        set_delay(0);
        for (int i = 0; i < 5; i++) send_gap(DW'($urandom));

        // Overrun, sticky until enable drops
        set_delay(3);
        strobe(DW'($urandom));
        dup_strobe();
        repeat (3) @(negedge clk);
        check("overrun_set", DW'(overrun), 18'd1);
        send_gap(DW'($urandom));
        repeat (4) @(negedge clk);
        check("overrun_sticky", DW'(overrun), 18'd1);
        enable = 1'b0;
        since = 0;
        @(negedge clk);
        check("disable_overrun", DW'(overrun), '0);
        check("disable_echo_out", echo_out, '0);
        enable = 1'b1;
        repeat (2) @(negedge clk);

        // Reset in the middle of a WRITE cycle
        strobe(DW'($urandom));
        dup_strobe();
        repeat (3) @(negedge clk);
        strobe(DW'($urandom));
        @(posedge clk);
        #1;
        check("pre_reset_overrun", DW'(overrun), 18'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check("midwrite_reset_echo_out", echo_out, '0);
        check("midwrite_reset_echo_valid", DW'(echo_valid), '0);
        check("midwrite_reset_overrun", DW'(overrun), '0);
        @(negedge clk);
        reset_n = 1'b1;
        since = 0;
        repeat (2) @(negedge clk);

        // Randomised stream with occasional delay changes
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 15) == 0) set_delay(int'($urandom_range(0, 15)));
            send_gap(DW'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        check_int("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
